// File: rtl/muldiv_unit_if.sv
// Request/response bundle for the M-extension multiply/divide unit.
// The pipeline side drives the request; the unit returns the status and the result.
interface muldiv_unit_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [2:0]      func3;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            flush;
    logic            ready;
    logic            busy;
    logic            valid;
    logic [XLEN-1:0] result;

    modport master (
        output start, func3, op_a, op_b, flush,
        input  ready, busy, valid, result
    );

    modport slave (
        input  start, func3, op_a, op_b, flush,
        output ready, busy, valid, result
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M unit: 32-cycle shift-add multiply and restoring divide on magnitudes.
// Divide-by-zero and signed overflow finish on the acceptance edge.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input logic          clk,
    input logic          rst,
    muldiv_unit_if.slave bus
);
    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_t            state;
    state_t            state_next;
    state_t            start_target;
    logic [4:0]        cnt;
    logic [1:0]        op_sel;
    logic              neg_q;
    logic              neg_r;
    logic [2*XLEN-1:0] mcand;
    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0]   mplier;
    logic [XLEN-1:0]   result_q;

    logic              accept;
    logic              last;
    logic              a_signed;
    logic              b_signed;
    logic              sign_a;
    logic              sign_b;
    logic              div_zero;
    logic              div_ovf;
    logic              special;
    logic [XLEN-1:0]   mag_a;
    logic [XLEN-1:0]   mag_b;
    logic [XLEN-1:0]   special_res;
    logic [2*XLEN-1:0] prod_step;
    logic [2*XLEN-1:0] prod_final;
    logic [XLEN-1:0]   mul_res;
    logic [XLEN:0]     div_trial;
    logic [XLEN:0]     div_diff;
    logic              div_ge;
    logic [XLEN-1:0]   rem_next;
    logic [XLEN-1:0]   quo_next;
    logic [XLEN-1:0]   div_res;

    assign bus.ready  = (state == IDLE) || (state == DONE);
    assign bus.busy   = (state == MUL) || (state == DIV);
    assign bus.valid  = (state == DONE);
    assign bus.result = result_q;

    assign accept = bus.start && !bus.flush && ((state == IDLE) || (state == DONE));
    assign last   = (cnt == 5'd31);

    // MULHU, DIVU and REMU are the fully unsigned forms; MULHSU keeps op_a signed only
    assign a_signed = !((bus.func3 == 3'b011) || (bus.func3 == 3'b101) || (bus.func3 == 3'b111));
    assign b_signed = a_signed && (bus.func3 != 3'b010);
    assign sign_a   = a_signed && bus.op_a[XLEN-1];
    assign sign_b   = b_signed && bus.op_b[XLEN-1];
    assign mag_a    = sign_a ? -bus.op_a : bus.op_a;
    assign mag_b    = sign_b ? -bus.op_b : bus.op_b;

    assign div_zero    = bus.func3[2] && (bus.op_b == '0);
    assign div_ovf     = bus.func3[2] && !bus.func3[0] && (bus.op_a == MIN_NEG) && (bus.op_b == '1);
    assign special     = div_zero || div_ovf;
    assign special_res = bus.func3[1] ? (div_zero ? bus.op_a : '0) : (div_zero ? '1 : MIN_NEG);

    assign start_target = special ? DONE : (bus.func3[2] ? DIV : MUL);

    assign prod_step  = acc + (mplier[0] ? mcand : '0);
    assign prod_final = neg_q ? -prod_step : prod_step;
    assign mul_res    = (op_sel == 2'b00) ? prod_final[XLEN-1:0] : prod_final[2*XLEN-1:XLEN];

    // acc holds {remainder, dividend/quotient}; the subtract borrow decides the quotient bit
    assign div_trial = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    assign div_diff  = div_trial - {1'b0, mplier};
    assign div_ge    = !div_diff[XLEN];
    assign rem_next  = div_ge ? div_diff[XLEN-1:0] : div_trial[XLEN-1:0];
    assign quo_next  = {acc[XLEN-2:0], div_ge};
    assign div_res   = op_sel[1] ? (neg_r ? -rem_next : rem_next)
                                 : (neg_q ? -quo_next : quo_next);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:     if (accept) state_next = start_target;
            MUL, DIV: begin
                if (bus.flush) begin
                    state_next = IDLE;
                end else if (last) begin
                    state_next = DONE;
                end
            end
            DONE:     state_next = accept ? start_target : IDLE;
            default:  state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            op_sel   <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            mcand    <= '0;
            acc      <= '0;
            mplier   <= '0;
            result_q <= '0;
        end else if (accept) begin
            cnt    <= '0;
            op_sel <= bus.func3[1:0];
            neg_q  <= sign_a ^ sign_b;
            neg_r  <= sign_a;
            mcand  <= {{XLEN{1'b0}}, mag_a};
            mplier <= mag_b;
            acc    <= bus.func3[2] ? {{XLEN{1'b0}}, mag_a} : '0;
            if (special) begin
                result_q <= special_res;
            end
        end else if ((state == MUL) && !bus.flush) begin
            cnt    <= cnt + 5'd1;
            acc    <= prod_step;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            if (last) begin
                result_q <= mul_res;
            end
        end else if ((state == DIV) && !bus.flush) begin
            cnt <= cnt + 5'd1;
            acc <= {rem_next, quo_next};
            if (last) begin
                result_q <= div_res;
            end
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: latency/arithmetic reference model checked every cycle,
// directed corner cases with literal results, then randomized traffic with flushes.
module tb_muldiv_unit;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    muldiv_unit_if #(.XLEN(32)) bus ();
    muldiv_unit #(.XLEN(32)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic bit is_special(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        return f[2] && ((b == 32'h0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    endfunction

    // Plain 64-bit arithmetic; -2^31 / -1 naturally yields 0x80000000 in the low word
    function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub, p;
        logic [63:0] pv;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'h0, a});
        ub = longint'({32'h0, b});
        case (f)
            3'd0, 3'd1: p = sa * sb;
            3'd2:       p = sa * ub;
            3'd3:       p = ua * ub;
            3'd4:       p = (b == 0) ? -1 : sa / sb;
            3'd5:       p = (b == 0) ? -1 : ua / ub;
            3'd6:       p = (b == 0) ? sa : sa % sb;
            default:    p = (b == 0) ? ua : ua % ub;
        endcase
        pv = p;
        if (f == 3'd1 || f == 3'd2 || f == 3'd3) return pv[63:32];
        return pv[31:0];
    endfunction

    // Latency model: a normal op is busy for 32 cycles and then valid for one
    int          m_left  = 0;
    logic        m_valid = 1'b0;
    logic [31:0] m_res   = 32'h0;
    logic [31:0] m_pend  = 32'h0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_left  <= 0;
            m_valid <= 1'b0;
            m_res   <= 32'h0;
        end else if (m_left != 0) begin
            if (bus.flush) begin
                m_left  <= 0;
                m_valid <= 1'b0;
            end else begin
                m_left  <= m_left - 1;
                m_valid <= (m_left == 1);
                if (m_left == 1) m_res <= m_pend;
            end
        end else begin
            m_valid <= 1'b0;
            if (bus.start && !bus.flush) begin
                if (is_special(bus.func3, bus.op_a, bus.op_b)) begin
                    m_res   <= ref_op(bus.func3, bus.op_a, bus.op_b);
                    m_valid <= 1'b1;
                end else begin
                    m_pend <= ref_op(bus.func3, bus.op_a, bus.op_b);
                    m_left <= 32;
                end
            end
        end
    end

    always @(negedge clk) begin
        check("cyc ready",  bus.ready,  (m_left == 0));
        check("cyc busy",   bus.busy,   (m_left != 0));
        check("cyc valid",  bus.valid,  m_valid);
        check("cyc result", bus.result, m_res);
    end

    task automatic wait_result(input string name, input logic [31:0] exp, input int lat);
        int n = 1;
        int nbusy = 0;
        bit done = 1'b0;
        while (!done && n <= lat + 4) begin
            @(negedge clk);
            if (bus.valid) begin
                check({name, " latency"}, n, lat);
                check({name, " busy cycles"}, nbusy, lat - 1);
                check({name, " result"}, bus.result, exp);
                check({name, " model"}, m_res, exp);
                done = 1'b1;
            end else if (bus.busy) begin
                nbusy++;
            end
            @(posedge clk);
            #1;
            n++;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: no valid within %0d cycles, required at cycle %0d", name, lat + 4, lat);
        end
    endtask

    task automatic do_op(input string name, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int lat);
        bus.func3 = f;
        bus.op_a  = a;
        bus.op_b  = b;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_result(name, exp, lat);
    endtask

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 6))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 20));
            4:       return -32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int nvalid;
        logic [31:0] exp1;
        logic [31:0] exp2;

        bus.start = 1'b0;
        bus.flush = 1'b0;
        bus.func3 = 3'd0;
        bus.op_a  = 32'h0;
        bus.op_b  = 32'h0;
        #1 rst = 1'b1;
        @(negedge clk);
        check("reset ready",  bus.ready,  1);
        check("reset busy",   bus.busy,   0);
        check("reset valid",  bus.valid,  0);
        check("reset result", bus.result, 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;

        do_op("MUL 7*-3",      3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
        do_op("MULH min*min",  3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 33);
        do_op("MULHU ff*ff",   3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
        do_op("MULHSU ff*ff",  3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
        do_op("DIV -7/2",      3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 33);
        do_op("REM -7/2",      3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 33);
        do_op("DIVU 100/7",    3'd5, 32'd100,        32'd7,         32'd14,        33);
        do_op("REMU 100/7",    3'd7, 32'd100,        32'd7,         32'd2,         33);
        do_op("DIV ovf",       3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1);
        do_op("REM ovf",       3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0,         1);
        do_op("DIV -9/0",      3'd4, 32'hFFFF_FFF7,  32'd0,         32'hFFFF_FFFF, 1);
        do_op("DIVU 5/0",      3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF, 1);
        do_op("REMU 5/0",      3'd7, 32'd5,          32'd0,         32'd5,         1);

        // Flush in cycle 10 of a divide
        bus.func3 = 3'd4;
        bus.op_a  = 32'd1000;
        bus.op_b  = 32'd3;
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        bus.flush = 1'b1;
        @(posedge clk);
        #1 bus.flush = 1'b0;
        @(negedge clk);
        check("flush busy",   bus.busy,   0);
        check("flush ready",  bus.ready,  1);
        check("flush result", bus.result, 32'd5);
        nvalid = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.valid) nvalid++;
        end
        check("flush no valid", nvalid, 0);
        @(posedge clk);
        #1;

        // Back-to-back: second start accepted in the DONE cycle of the first
        exp1 = ref_op(3'd0, 32'd12345, 32'd1000);
        exp2 = ref_op(3'd3, 32'hDEAD_BEEF, 32'h1234_5678);
        bus.func3 = 3'd0;
        bus.op_a  = 32'd12345;
        bus.op_b  = 32'd1000;
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (32) begin
            @(posedge clk);
            #1;
        end
        bus.func3 = 3'd3;
        bus.op_a  = 32'hDEAD_BEEF;
        bus.op_b  = 32'h1234_5678;
        bus.start = 1'b1;
        @(negedge clk);
        check("b2b first valid",  bus.valid,  1);
        check("b2b first ready",  bus.ready,  1);
        check("b2b first result", bus.result, 32'h00BC_5EA8);
        @(posedge clk);
        #1 bus.start = 1'b0;
        wait_result("b2b second", exp2, 33);
        check("b2b model first", exp1, 32'h00BC_5EA8);

        // Asynchronous reset in the middle of cycle 15 of a multiply
        bus.func3 = 3'd0;
        bus.op_a  = 32'h1234_5678;
        bus.op_b  = 32'h0000_0FFF;
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (14) begin
            @(posedge clk);
            #1;
        end
        #2 rst = 1'b1;
        #1;
        check("async rst ready",  bus.ready,  1);
        check("async rst busy",   bus.busy,   0);
        check("async rst valid",  bus.valid,  0);
        check("async rst result", bus.result, 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        nvalid = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.valid) nvalid++;
        end
        check("rst no valid", nvalid, 0);
        @(posedge clk);
        #1;

        for (int i = 0; i < 6000; i++) begin
            bus.start = ($urandom_range(0, 2) == 0);
            bus.flush = ($urandom_range(0, 60) == 0);
            bus.func3 = 3'($urandom_range(0, 7));
            bus.op_a  = rand_operand();
            bus.op_b  = rand_operand();
            @(posedge clk);
            #1;
        end
        bus.start = 1'b0;
        bus.flush = 1'b0;
        repeat (40) @(posedge clk);
        #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
